mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
Parametrised multicycle successor to the single-cycle MIPS datapath. It holds its own control FSM, register file and ALU, and executes add, sub, and, or, slt, addi, lw, sw, beq and j. Instruction and data traffic share one memory port with a valid/ready handshake, so memory wait states stall the FSM. It sits between the top level and a unified instruction/data memory.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
ADDR_W, 32, width of mem_addr; carries the low ADDR_W bits of the internal 32-bit byte address.
CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset; 0 resets the block immediately.
mem_req  out  1  memory request; high only in FETCH and MEM states.
mem_we  out  1  1 = write (sw only).
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  32  store data (register B).
mem_ready  in  1  memory accepts or completes the request this cycle.
mem_rdata  in  32  read data; valid in the cycle where mem_req & mem_ready.
pc  out  32  current PC.
retire  out  1  one-cycle pulse when an instruction completes.
halted  out  1  sticky halt flag.
cycle_cnt  out  CNT_W  cycle counter (optional feature).
instret_cnt  out  CNT_W  retired-instruction counter (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 registers=0, mem_req=0, mem_we=0, retire=0, halted=0.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata are held stable until the cycle where mem_ready=1. The transfer completes in that cycle. mem_ready while mem_req=0 is ignored.
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- BOOT -> FETCH unconditionally.
- FETCH: mem_addr=pc, mem_we=0. On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE. Otherwise stay.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=pc+(sext(imm)<<2) (branch target). An illegal opcode, or an R-type funct not in {0x20,0x22,0x24,0x25,0x2A}, goes to HALT.
- EXEC, R-type: ALUOut<=A op B, go to WB.
- EXEC, addi/lw/sw: ALUOut<=A+sext(imm). addi goes to WB. lw/sw go to MEM, except that a sum with [1:0]!=0 goes to HALT with no memory access.
- EXEC, beq: if A==B, pc<=ALUOut. Go to FETCH; the instruction retires.
- EXEC, j: pc<={pc[31:28],IR[25:0],2'b00}. Go to FETCH; the instruction retires.
- MEM: mem_addr=ALUOut[ADDR_W-1:0].
  - lw: on ready, MDR<=mem_rdata, go to WB.
  - sw: mem_we=1, mem_wdata=B; on ready, go to FETCH and retire.
- WB: write ALUOut (R-type/addi) or MDR (lw) to rd (R-type) or rt (addi/lw). Go to FETCH and retire.
- HALT: absorbing state. halted=1, mem_req=0, no further register or pc updates. Only reset leaves it.
- Register $0 always reads 0; writes to it are dropped.
- slt is a signed compare, result 32'd1 or 32'd0. Arithmetic wraps modulo 2^32 with no overflow trap. PC increments wrap at 2^32.
- Cycle counts with zero-wait memory: beq/j 3, R/addi/sw 4, lw 5. Each memory wait cycle adds one.
- retire is registered. It is high for exactly the one cycle following each completing transition into FETCH.
- If reset asserts mid-transaction, mem_req drops immediately. The memory must tolerate the abandoned request.

Optional Feature:
MC_DATAPATH_PERF_EN
- Defined:
  - cycle_cnt increments every cycle out of reset.
  - instret_cnt increments on every retire pulse.
  - Both freeze while halted, wrap modulo 2^CNT_W, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset release, mem_ready=1, mem_rdata=addi $1,$0,5 (0x20010005): FETCH at 0x0, R1=5 after 4 cycles, pc=0x4, one retire pulse.
- R-type with R1=5, R2=7: sub $3,$1,$2 -> R3=0xFFFFFFFE; slt $4,$1,$2 -> R4=1; add $0,$1,$2 -> R0 stays 0.
- sw $1,8($0) with R1=0xDEADBEEF: mem_we=1, mem_addr=8, mem_wdata=0xDEADBEEF. lw $5,8($0) with mem_ready held low 3 cycles: addr/we held stable throughout, R5 loads when ready rises, lw takes 8 cycles.
- beq taken at pc=0x10 with offset 0x0003: pc=0x20. Not-taken case: pc=0x14. j 0x0000040 from pc=0x24: pc=0x100. Each takes 3 cycles.
- lw with address 0x6 -> HALT, no mem_req. Opcode 0x3F -> HALT. In both, halted=1 stays set and pc is frozen until rst=0.
- With MC_DATAPATH_PERF_EN: after 10 addi instructions at zero wait, instret_cnt=10 and cycle_cnt=41 (including BOOT). rst asserted mid-FETCH clears both counters and mem_req asynchronously.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath (control FSM, register file, ALU) on one shared valid/ready memory port.
// Optional: define MC_DATAPATH_PERF_EN to build the cycle_cnt / instret_cnt performance counters.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] ir, a, b, alu_out, mdr;
  logic [XLEN-1:0] pc_d, ir_d, a_d, b_d, alu_d, mdr_d;
  logic [XLEN-1:0] regs [NREG];
  logic            rf_we, retire_d, xfer, legal;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata, imm_sext, r_result, ea;

  wire [5:0] opcode = ir[31:26];
  wire [4:0] rs     = ir[25:21];
  wire [4:0] rt     = ir[20:16];
  wire [4:0] rd     = ir[15:11];
  wire [5:0] funct  = ir[5:0];

  assign xfer     = mem_req & mem_ready;
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign ea       = a + imm_sext;

  // Decode legality and R-type ALU
  always_comb begin
    legal    = 1'b0;
    r_result = '0;
    case (opcode)
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      OP_R: legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT);
      default: legal = 1'b0;
    endcase
    case (funct)
      F_ADD:   r_result = a + b;
      F_SUB:   r_result = a - b;
      F_AND:   r_result = a & b;
      F_OR:    r_result = a | b;
      F_SLT:   r_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r_result = '0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    ir_d     = ir;
    a_d      = a;
    b_d      = b;
    alu_d    = alu_out;
    mdr_d    = mdr;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    retire_d = 1'b0;
    case (state)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata;
          pc_d    = pc + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs[rs];
        b_d     = regs[rt];
        alu_d   = pc + {imm_sext[29:0], 2'b00};
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_d   = r_result;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = ea;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = ea;
            state_d = (ea[1:0] != 2'b00) ? S_HALT : S_MEM;
          end
          OP_BEQ: begin
            if (a == b) pc_d = alu_out;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          OP_J: begin
            pc_d     = {pc[31:28], ir[25:0], 2'b00};
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (xfer) begin
          if (opcode == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_R) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr : alu_out;
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State, datapath registers and registered memory-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      a         <= a_d;
      b         <= b_d;
      alu_out   <= alu_d;
      mdr       <= mdr_d;
      mem_req   <= (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we    <= (state_d == S_MEM) && (ir_d[31:26] == OP_SW);
      mem_addr  <= (state_d == S_FETCH) ? ADDR_W'(pc_d) : ADDR_W'(alu_d);
      mem_wdata <= b_d;
      retire    <= retire_d;
      halted    <= (state_d == S_HALT);
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MC_DATAPATH_PERF_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (!halted) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire_d) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Directed self-checking bench for mc_datapath with a unified instruction/data memory model.
module tb_mc_datapath;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_req, mem_we, mem_ready, retire, halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, pc;
  logic [CNT_W-1:0]  cycle_cnt, instret_cnt;

  logic [31:0] prog   [0:127];
  logic [31:0] wmem   [0:127];
  logic        wvalid [0:127];
  logic        hold_low = 1'b0;
  int          total = 0;
  int          bad   = 0;
  logic [6:0]  idx;

  always #5 clk = ~clk;

  mc_datapath #(.RESET_PC(32'h0), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halted(halted), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  assign idx       = mem_addr[8:2];
  assign mem_ready = !hold_low;
  assign mem_rdata = wvalid[idx] ? wmem[idx] : prog[idx];

  // Stores land in a shadow array that reset wipes, so each program starts clean
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) wvalid[i] <= 1'b0;
    end else if (mem_req && mem_we && mem_ready) begin
      wmem[idx]   <= mem_wdata;
      wvalid[idx] <= 1'b1;
    end
  end

  function automatic logic [31:0] rdmem(input int i);
    return wvalid[i] ? wmem[i] : prog[i];
  endfunction

  task automatic fill_halt;
    for (int i = 0; i < 128; i++) prog[i] = HALT_W;
  endtask

  task automatic do_reset;
    rst      = 1'b0;
    hold_low = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    fill_halt();
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL reset_retire got=%b exp=0", retire); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (cycle_cnt !== '0 || instret_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
    end
  endtask

  // addi $1,$0,5 then sw $1,0xF0($0)
  task automatic test_addi;
    fill_halt();
    prog[0] = 32'h2001_0005;
    prog[1] = 32'hAC01_00F0;
    do_reset();
    tick(1);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL addi_fetch got=req%b addr%h we%b exp=req1 addr0 we0", mem_req, mem_addr, mem_we);
    end
    tick(3);
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL addi_early_retire got=%b exp=0", retire); end
    tick(1);
    total++; if (retire !== 1'b1 || pc !== 32'h4) begin
      bad++; $display("FAIL addi_retire got=ret%b pc%h exp=ret1 pc4", retire, pc);
    end
    tick(1);
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL addi_pulse got=%b exp=0", retire); end
    tick(2);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'hF0 || mem_wdata !== 32'd5) begin
      bad++; $display("FAIL addi_sw got=req%b we%b addr%h wd%h exp=1 1 f0 5", mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick(1);
    total++; if (rdmem(60) !== 32'd5) begin bad++; $display("FAIL addi_r1 got=%h exp=5", rdmem(60)); end
  endtask

  task automatic test_rtype;
    fill_halt();
    prog[0]  = 32'h2001_0005; // addi $1,$0,5
    prog[1]  = 32'h2002_0007; // addi $2,$0,7
    prog[2]  = 32'h0022_1822; // sub $3,$1,$2
    prog[3]  = 32'h0022_202A; // slt $4,$1,$2
    prog[4]  = 32'h0022_0020; // add $0,$1,$2
    prog[5]  = 32'h0022_2824; // and $5,$1,$2
    prog[6]  = 32'h0022_3025; // or  $6,$1,$2
    prog[7]  = 32'h0061_382A; // slt $7,$3,$1 (signed: -2 < 5)
    prog[8]  = 32'hAC03_00E0;
    prog[9]  = 32'hAC04_00E4;
    prog[10] = 32'hAC00_00E8;
    prog[11] = 32'hAC05_00EC;
    prog[12] = 32'hAC06_00F0;
    prog[13] = 32'hAC07_00F4;
    prog[58] = 32'h5555_5555;
    do_reset();
    tick(70);
    total++; if (rdmem(56) !== 32'hFFFF_FFFE) begin bad++; $display("FAIL r_sub got=%h exp=fffffffe", rdmem(56)); end
    total++; if (rdmem(57) !== 32'd1) begin bad++; $display("FAIL r_slt got=%h exp=1", rdmem(57)); end
    total++; if (rdmem(58) !== 32'd0) begin bad++; $display("FAIL r_zero got=%h exp=0", rdmem(58)); end
    total++; if (rdmem(59) !== 32'd5) begin bad++; $display("FAIL r_and got=%h exp=5", rdmem(59)); end
    total++; if (rdmem(60) !== 32'd7) begin bad++; $display("FAIL r_or got=%h exp=7", rdmem(60)); end
    total++; if (rdmem(61) !== 32'd1) begin bad++; $display("FAIL r_slt_signed got=%h exp=1", rdmem(61)); end
    total++; if (halted !== 1'b1 || pc !== 32'h3C) begin
      bad++; $display("FAIL r_end got=halt%b pc%h exp=halt1 pc3c", halted, pc);
    end
  endtask

  task automatic test_mem_wait;
    fill_halt();
    prog[0]  = 32'h0800_0008; // j 0x20
    prog[8]  = 32'h8C01_0040; // lw $1,0x40($0)
    prog[9]  = 32'hAC01_0008; // sw $1,8($0)
    prog[10] = 32'h8C05_0008; // lw $5,8($0)
    prog[11] = 32'hAC05_0044; // sw $5,0x44($0)
    prog[16] = 32'hDEAD_BEEF;
    do_reset();
    tick(12);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sw_port got=req%b we%b addr%h wd%h exp=1 1 8 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick(3);
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8) begin
        bad++; $display("FAIL lw_hold%0d got=req%b we%b addr%h exp=1 0 8", k, mem_req, mem_we, mem_addr);
      end
    end
    hold_low = 1'b0;
    tick(1);
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL lw_early got=%b exp=0", retire); end
    tick(1);
    total++; if (retire !== 1'b1 || pc !== 32'h2C) begin
      bad++; $display("FAIL lw_done got=ret%b pc%h exp=ret1 pc2c", retire, pc);
    end
    tick(9);
    total++; if (rdmem(2) !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_data got=%h exp=deadbeef", rdmem(2)); end
    total++; if (rdmem(17) !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rdmem(17)); end
  endtask

  task automatic test_branch;
    fill_halt();
    prog[0]  = 32'h2001_0001; // addi $1,$0,1
    prog[1]  = 32'h2002_0001; // addi $2,$0,1
    prog[2]  = 32'h2003_0002; // addi $3,$0,2
    prog[3]  = 32'h2004_0009; // addi $4,$0,9
    prog[4]  = 32'h1022_0003; // beq $1,$2,+3 (taken)
    prog[8]  = 32'h1023_0003; // beq $1,$3,+3 (not taken)
    prog[9]  = 32'h0800_0040; // j 0x100
    prog[64] = 32'hAC04_01F0; // sw $4,0x1F0($0)
    do_reset();
    tick(19);
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL beq_inc got=%h exp=14", pc); end
    tick(1);
    total++; if (pc !== 32'h20 || retire !== 1'b1 || mem_addr !== 32'h20) begin
      bad++; $display("FAIL beq_taken got=pc%h ret%b addr%h exp=20 1 20", pc, retire, mem_addr);
    end
    tick(3);
    total++; if (pc !== 32'h24 || retire !== 1'b1) begin
      bad++; $display("FAIL beq_not got=pc%h ret%b exp=24 1", pc, retire);
    end
    tick(3);
    total++; if (pc !== 32'h100 || retire !== 1'b1 || mem_addr !== 32'h100) begin
      bad++; $display("FAIL jump got=pc%h ret%b addr%h exp=100 1 100", pc, retire, mem_addr);
    end
    tick(14);
    total++; if (rdmem(124) !== 32'd9 || halted !== 1'b1) begin
      bad++; $display("FAIL jump_sw got=%h halt%b exp=9 halt1", rdmem(124), halted);
    end
  endtask

  // Each illegal case: word, edges until HALT
  task automatic test_halt;
    logic [31:0] words [3];
    int          lat   [3];
    words[0] = 32'h8C01_0006; lat[0] = 4; // misaligned lw
    words[1] = 32'hFC00_0000; lat[1] = 3; // opcode 0x3F
    words[2] = 32'h0000_0000; lat[2] = 3; // R-type funct 0
    for (int c = 0; c < 3; c++) begin
      fill_halt();
      prog[0] = words[c];
      do_reset();
      tick(lat[c] - 1);
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early%0d got=%b exp=0", c, halted); end
      tick(1);
      total++; if (halted !== 1'b1 || pc !== 32'h4 || mem_req !== 1'b0) begin
        bad++; $display("FAIL halt_enter%0d got=halt%b pc%h req%b exp=1 4 0", c, halted, pc, mem_req);
      end
      for (int k = 0; k < 6; k++) begin
        tick(1);
        total++; if (halted !== 1'b1 || pc !== 32'h4 || mem_req !== 1'b0 || retire !== 1'b0) begin
          bad++; $display("FAIL halt_stay%0d got=halt%b pc%h req%b ret%b exp=1 4 0 0", c, halted, pc, mem_req, retire);
        end
      end
    end
  endtask

  task automatic test_perf;
    logic [CNT_W-1:0] exp_cyc, exp_ins, exp_cyc3;
`ifdef MC_DATAPATH_PERF_EN
    exp_cyc = CNT_W'(41); exp_ins = CNT_W'(10); exp_cyc3 = CNT_W'(3);
`else
    exp_cyc = '0; exp_ins = '0; exp_cyc3 = '0;
`endif
    fill_halt();
    for (int i = 0; i < 10; i++) prog[i] = 32'h2021_0001; // addi $1,$1,1
    do_reset();
    tick(41);
    total++; if (cycle_cnt !== exp_cyc || instret_cnt !== exp_ins) begin
      bad++; $display("FAIL perf_cnt got=%0d/%0d exp=%0d/%0d", cycle_cnt, instret_cnt, exp_cyc, exp_ins);
    end
    total++; if (pc !== 32'h28 || retire !== 1'b1) begin
      bad++; $display("FAIL perf_pc got=pc%h ret%b exp=28 1", pc, retire);
    end
    tick(10);
    total++; if (halted !== 1'b1 || cycle_cnt !== exp_cyc + CNT_W'(2) - ((exp_cyc == '0) ? CNT_W'(2) : '0)) begin
      bad++; $display("FAIL perf_freeze got=halt%b cyc%0d", halted, cycle_cnt);
    end
    do_reset();
    hold_low = 1'b1;
    tick(3);
    total++; if (mem_req !== 1'b1 || cycle_cnt !== exp_cyc3) begin
      bad++; $display("FAIL stall_fetch got=req%b cyc%0d exp=1 %0d", mem_req, cycle_cnt, exp_cyc3);
    end
    #2;
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || pc !== 32'h0 || cycle_cnt !== '0 || instret_cnt !== '0) begin
      bad++; $display("FAIL async_rst got=req%b pc%h cnt%0d/%0d exp=0 0 0/0", mem_req, pc, cycle_cnt, instret_cnt);
    end
    hold_low = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_mem_wait();
    test_branch();
    test_halt();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
